ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 125 ++++++++++++
 tb/tb_ifu.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding request, holds each fetched word until decode takes it.
// Optional IFU_EBREAK_HALT_EN stops fetching after an accepted ebreak until reset.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_snpc,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_halted
);

    // state  | meaning
    // S_REQ  | request presented to imem (valid rises one edge after reset)
    // S_WAIT | request accepted, waiting for response data
    // S_HOLD | instruction held for decode until inst_ready
    // S_HALT | ebreak accepted, fetch stopped until reset
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_req_valid;
    logic        r_inst_valid;
    logic        r_halted;

    logic [31:0] w_snpc;
    logic [31:0] w_redirect_tgt;
    logic [31:0] w_next_pc;
    logic        w_is_ebreak;

    assign w_snpc         = r_pc + 32'd4;
    assign w_redirect_tgt = i_redirect_pc & 32'hFFFF_FFFC;
    assign w_next_pc      = i_redirect_valid ? w_redirect_tgt : w_snpc;

`ifdef IFU_EBREAK_HALT_EN
    assign w_is_ebreak = (r_inst == EBREAK_INST);
`else
    assign w_is_ebreak = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_inst       <= NOP_INST;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (!r_req_valid) begin
                        r_req_valid <= 1'b1;
                    end else if (i_imem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rsp_valid) begin
                        r_inst       <= i_imem_rsp_data;
                        r_inst_valid <= 1'b1;
                        r_state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_inst_ready) begin
                        r_inst_valid <= 1'b0;
                        if (w_is_ebreak) begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end else begin
                            r_pc        <= w_next_pc;
                            r_req_valid <= 1'b1;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    r_req_valid  <= 1'b0;
                    r_inst_valid <= 1'b0;
                end
                default: begin
                    r_req_valid  <= 1'b0;
                    r_inst_valid <= 1'b0;
                    r_state      <= S_REQ;
                end
            endcase
        end
    end

    assign o_imem_req_valid = r_req_valid;
    assign o_imem_req_addr  = r_pc;
    assign o_inst_valid     = r_inst_valid;
    assign o_inst           = r_inst;
    assign o_pc             = r_pc;
    assign o_snpc           = w_snpc;

`ifdef IFU_EBREAK_HALT_EN
    assign o_halted = r_halted;
`else
    // Halting is compiled out; the flag register is dead and folds away.
    assign o_halted = r_halted & 1'b0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu; define IFU_EBREAK_HALT_EN on both files to exercise halting.
`timescale 1ns/1ps
module tb_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    int n_checks;
    int n_errors;

    ifu #(.RESET_PC(RESET_PC)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req_valid (imem_req_valid),
        .i_imem_req_ready (imem_req_ready),
        .o_imem_req_addr  (imem_req_addr),
        .i_imem_rsp_valid (imem_rsp_valid),
        .i_imem_rsp_data  (imem_rsp_data),
        .o_inst_valid     (inst_valid),
        .i_inst_ready     (inst_ready),
        .o_inst           (inst),
        .o_pc             (pc),
        .o_snpc           (snpc),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_halted         (halted)
    );

    always #5 clk = ~clk;

    // Starting at a negedge in REQ with request valid; ends at a negedge in HOLD.
    task automatic fetch_to_hold(input logic [31:0] data);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    task automatic accept(input logic rv, input logic [31:0] rpc);
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = 1'b1;
        @(negedge clk);
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pc !== RESET_PC) begin
            n_errors++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC);
        end
        n_checks++;
        if (inst !== 32'h0000_0013) begin
            n_errors++; $display("FAIL reset_inst: got %h expected %h", inst, 32'h13);
        end
        n_checks++;
        if ({imem_req_valid, inst_valid, halted} !== 3'b000) begin
            n_errors++; $display("FAIL reset_flags: got %b expected 000", {imem_req_valid, inst_valid, halted});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_errors++; $display("FAIL first_req: got v=%b a=%h expected v=1 a=%h", imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_basic();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_errors++; $display("FAIL basic_wait: got req=%b iv=%b expected 0 0", imem_req_valid, inst_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0093;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0000_0093 || pc !== 32'h8000_0000 || snpc !== 32'h8000_0004) begin
            n_errors++; $display("FAIL basic_hold: got iv=%b inst=%h pc=%h snpc=%h expected 1 00000093 80000000 80000004",
                                 inst_valid, inst, pc, snpc);
        end
        accept(1'b0, 32'h0);
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
            n_errors++; $display("FAIL basic_next: got iv=%b req=%b addr=%h expected 0 1 80000004", inst_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_stall();
        int iv_cnt;
        int rv_cnt;
        iv_cnt = 0;
        rv_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
                n_errors++; $display("FAIL stall_req_hold: got v=%b a=%h expected 1 80000004", imem_req_valid, imem_req_addr);
            end
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        inst_ready     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (inst_valid === 1'b1) iv_cnt++;
            if (i <= 4 && imem_req_valid === 1'b1) rv_cnt++;
            if (i == 4) begin
                n_checks++;
                if (inst !== 32'h0000_0113 || pc !== 32'h8000_0004) begin
                    n_errors++; $display("FAIL stall_inst: got inst=%h pc=%h expected 00000113 80000004", inst, pc);
                end
            end
            imem_rsp_valid = (i == 3 || i == 7);
            imem_rsp_data  = (i == 3) ? 32'h0000_0113 : 32'hDEAD_BEEF;
            @(negedge clk);
        end
        inst_ready     = 1'b0;
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (iv_cnt !== 1) begin
            n_errors++; $display("FAIL stall_one_inst_valid: got %0d expected 1", iv_cnt);
        end
        n_checks++;
        if (rv_cnt !== 0) begin
            n_errors++; $display("FAIL stall_dup_fetch: got %0d expected 0", rv_cnt);
        end
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008 || inst !== 32'h0000_0113) begin
            n_errors++; $display("FAIL stall_after: got v=%b a=%h inst=%h expected 1 80000008 00000113",
                                 imem_req_valid, imem_req_addr, inst);
        end
    endtask

    task automatic test_decode_stall();
        fetch_to_hold(32'h0020_8093);
        for (int i = 0; i < 5; i++) begin
            redirect_valid = (i == 1 || i == 2);
            redirect_pc    = 32'h1234_5678;
            @(negedge clk);
            n_checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h0020_8093 || pc !== 32'h8000_0008) begin
                n_errors++; $display("FAIL dstall_hold: got iv=%b inst=%h pc=%h expected 1 00208093 80000008", inst_valid, inst, pc);
            end
        end
        redirect_valid = 1'b0;
        accept(1'b0, 32'h0);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_000C) begin
            n_errors++; $display("FAIL dstall_next: got v=%b a=%h expected 1 8000000c", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect();
        fetch_to_hold(32'h0000_006F);
        accept(1'b1, 32'h8000_0102);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
            n_errors++; $display("FAIL redirect_addr: got v=%b a=%h expected 1 80000100", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_wrap();
        fetch_to_hold(32'h0000_0013);
        accept(1'b1, 32'hFFFF_FFFE);
        n_checks++;
        if (imem_req_addr !== 32'hFFFF_FFFC || snpc !== 32'h0000_0000) begin
            n_errors++; $display("FAIL wrap_top: got a=%h snpc=%h expected fffffffc 00000000", imem_req_addr, snpc);
        end
        fetch_to_hold(32'h0000_0013);
        accept(1'b0, 32'h0);
        n_checks++;
        if (imem_req_addr !== 32'h0000_0000 || snpc !== 32'h0000_0004 || halted !== 1'b0) begin
            n_errors++; $display("FAIL wrap_zero: got a=%h snpc=%h h=%b expected 00000000 00000004 0", imem_req_addr, snpc, halted);
        end
    endtask

    task automatic test_reset_mid();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL rmid_wait: got req=%b expected 0", imem_req_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pc !== RESET_PC || inst !== 32'h0000_0013 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_errors++; $display("FAIL rmid_reset: got pc=%h inst=%h req=%b iv=%b expected %h 00000013 0 0",
                                 pc, inst, imem_req_valid, inst_valid, RESET_PC);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b1) begin
            n_errors++; $display("FAIL rmid_req_rise: got %b expected 1", imem_req_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0BAD;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0000_0013 || imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_errors++; $display("FAIL rmid_stale: got iv=%b inst=%h req=%b a=%h expected 0 00000013 1 %h",
                                 inst_valid, inst, imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_ebreak();
        fetch_to_hold(32'h0010_0073);
        n_checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0010_0073) begin
            n_errors++; $display("FAIL ebreak_hold: got iv=%b inst=%h expected 1 00100073", inst_valid, inst);
        end
        accept(1'b0, 32'h0);
`ifdef IFU_EBREAK_HALT_EN
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (halted !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== RESET_PC) begin
                n_errors++; $display("FAIL ebreak_halted: got h=%b req=%b iv=%b pc=%h expected 1 0 0 %h",
                                     halted, imem_req_valid, inst_valid, pc, RESET_PC);
            end
            @(negedge clk);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (halted !== 1'b0 || pc !== RESET_PC) begin
            n_errors++; $display("FAIL ebreak_reset: got h=%b pc=%h expected 0 %h", halted, pc, RESET_PC);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            n_errors++; $display("FAIL ebreak_resume: got v=%b a=%h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
`else
        n_checks++;
        if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
            n_errors++; $display("FAIL ebreak_plain: got h=%b v=%b a=%h expected 0 1 80000004", halted, imem_req_valid, imem_req_addr);
        end
`endif
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        clk            = 1'b0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        test_reset();
        test_basic();
        test_stall();
        test_decode_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_ebreak();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
